// File: rtl/fft_bin_window.sv
// Selects a contiguous window of FFT bins from one lane of a multi-lane AXI4-Stream
// and forwards it through a 2-entry skid buffer. Define FFT_BIN_WINDOW_ERR_EN for frame-length error pulses.
module fft_bin_window #(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_LANES  = 8,
    parameter int FFT_LENGTH = 512,
    localparam int CNT_W  = $clog2(FFT_LENGTH),
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [CNT_W-1:0]                 cfg_start,
    input  logic [CNT_W:0]                   cfg_len,
    input  logic [LANE_W-1:0]                cfg_lane,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [CNT_W-1:0]                 m_axis_tuser
`ifdef FFT_BIN_WINDOW_ERR_EN
    ,
    output logic                             err_early_last,
    output logic                             err_missing_last
`endif
);

    typedef enum logic [1:0] {ST_PRE, ST_KEEP, ST_POST} state_t;

    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_LENGTH - 1);
    localparam logic [CNT_W+1:0] LEN_X    = (CNT_W+2)'(FFT_LENGTH);

    logic [CNT_W-1:0]  bin_cnt_q, bin_cnt_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  start_sh_q;
    logic [CNT_W:0]    end_sh_q;
    logic [LANE_W-1:0] lane_sh_q;
    logic              ready_en_q;

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, rd_ptr_q;

    logic [DATA_WIDTH-1:0] ent_data [2];
    logic                  ent_last [2];
    logic [CNT_W-1:0]      ent_user [2];
    logic [DATA_WIDTH-1:0] lane_data [NUM_LANES];

    logic              first_bin, accept, wrap, keep, push, pop, beat_last, in_window;
    logic [CNT_W+1:0]  cfg_sum;
    logic [CNT_W:0]    cfg_end, cur_end, next_x;
    logic [CNT_W-1:0]  cur_start;
    logic [LANE_W-1:0] cur_lane;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Bin 0 takes its window straight from the cfg ports; later bins use the shadows.
    assign first_bin = (bin_cnt_q == '0);
    assign cfg_sum   = {2'b00, cfg_start} + {1'b0, cfg_len};
    assign cfg_end   = (cfg_sum > LEN_X) ? LEN_X[CNT_W:0] : cfg_sum[CNT_W:0];
    assign cur_start = first_bin ? cfg_start : start_sh_q;
    assign cur_end   = first_bin ? cfg_end   : end_sh_q;
    assign cur_lane  = first_bin ? cfg_lane  : lane_sh_q;
    assign in_window = (bin_cnt_q >= cfg_start) && ({1'b0, bin_cnt_q} < cfg_end);
    assign keep      = first_bin ? in_window : (state_q == ST_KEEP);

    assign s_axis_tready = ready_en_q && (!keep || (count_q != 2'd2));
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign wrap      = s_axis_tlast || (bin_cnt_q == LAST_BIN);
    assign push      = accept && keep;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign next_x    = {1'b0, bin_cnt_q} + (CNT_W+1)'(1);
    assign beat_last = s_axis_tlast || ({1'b0, bin_cnt_q} == cur_end - (CNT_W+1)'(1));

    always_comb begin
        state_d   = state_q;
        bin_cnt_d = bin_cnt_q;
        if (accept) begin
            if (wrap) begin
                bin_cnt_d = '0;
                state_d   = ST_PRE;
            end else begin
                bin_cnt_d = bin_cnt_q + CNT_W'(1);
                if (next_x < {1'b0, cur_start}) begin
                    state_d = ST_PRE;
                end else if (next_x < cur_end) begin
                    state_d = ST_KEEP;
                end else begin
                    state_d = ST_POST;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bin_cnt_q  <= '0;
            state_q    <= ST_PRE;
            start_sh_q <= '0;
            end_sh_q   <= '0;
            lane_sh_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            bin_cnt_q  <= bin_cnt_d;
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (accept && first_bin) begin
                start_sh_q <= cfg_start;
                end_sh_q   <= cfg_end;
                lane_sh_q  <= cfg_lane;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] data_q;
            logic                  last_q;
            logic [CNT_W-1:0]      user_q;
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    data_q <= '0;
                    last_q <= 1'b0;
                    user_q <= '0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    data_q <= lane_data[cur_lane];
                    last_q <= beat_last;
                    user_q <= bin_cnt_q;
                end
            end
            assign ent_data[gi] = data_q;
            assign ent_last[gi] = last_q;
            assign ent_user[gi] = user_q;
        end
    endgenerate

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = ent_data[rd_ptr_q];
    assign m_axis_tlast  = ent_last[rd_ptr_q];
    assign m_axis_tuser  = ent_user[rd_ptr_q];

`ifdef FFT_BIN_WINDOW_ERR_EN
    logic err_early_q, err_missing_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            err_early_q   <= accept && s_axis_tlast && (bin_cnt_q != LAST_BIN);
            err_missing_q <= accept && !s_axis_tlast && (bin_cnt_q == LAST_BIN);
        end
    end
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;
`endif

endmodule

// File: tb/tb_fft_bin_window.sv
// Self-checking bench for fft_bin_window: table of frame scenarios driven with random
// data/handshakes, every output beat compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_fft_bin_window;
    localparam int DW = 48;
    localparam int NL = 8;
    localparam int N  = 512;
    localparam int CW = 9;
    localparam int LW = 3;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [CW-1:0]     cfg_start = '0;
    logic [CW:0]       cfg_len = '0;
    logic [LW-1:0]     cfg_lane = '0;
    logic [NL*DW-1:0]  s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b0;
    logic [CW-1:0]     m_axis_tuser;
`ifdef FFT_BIN_WINDOW_ERR_EN
    logic              err_early_last;
    logic              err_missing_last;
    logic              exp_early_now = 1'b0;
    logic              exp_miss_now  = 1'b0;
`endif

    fft_bin_window #(.DATA_WIDTH(DW), .NUM_LANES(NL), .FFT_LENGTH(N)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_lane(cfg_lane),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser)
`ifdef FFT_BIN_WINDOW_ERR_EN
        , .err_early_last(err_early_last), .err_missing_last(err_missing_last)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int start, len, lane, nb, tl, rdy, vgap, chg, nlen;
        int cnt, fu, lu;
    } test_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [CW-1:0] u;
    } obeat_t;

    int checks = 0;
    int passes = 0;

    // Reference model state: frame window captured at bin 0, expected output queue.
    int     m_bin = 0;
    int     m_start = 0, m_end = 0, m_lane = 0;
    int     occ = 0;
    obeat_t exp_q[$];
    logic   acc_prev = 1'b0;
    logic   prev_stall = 1'b0;
    obeat_t prev_out;
    int     out_cnt, first_u, last_u, tlast_cnt;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int win_end(input int s, input int l);
        return (s + l > N) ? N : s + l;
    endfunction

    function automatic logic model_keep(input int bin);
        int s, e;
        if (bin == 0) begin
            s = int'(cfg_start);
            e = win_end(int'(cfg_start), int'(cfg_len));
        end else begin
            s = m_start;
            e = m_end;
        end
        return (bin >= s) && (bin < e);
    endfunction

    function automatic test_t mk(input int s, input int l, input int ln, input int nb,
                                 input int tl, input int rdy, input int vgap,
                                 input int chg, input int nlen,
                                 input int cnt, input int fu, input int lu);
        test_t t;
        t.start = s; t.len = l; t.lane = ln; t.nb = nb; t.tl = tl; t.rdy = rdy;
        t.vgap = vgap; t.chg = chg; t.nlen = nlen; t.cnt = cnt; t.fu = fu; t.lu = lu;
        return t;
    endfunction

    function automatic test_t mk_rand();
        int s, l, e, c;
        s = $urandom_range(0, N - 1);
        l = $urandom_range(0, 300);
        e = win_end(s, l);
        c = e - s;
        return mk(s, l, $urandom_range(0, NL - 1), N, N - 1, 1, 1, -1, 0,
                  c, (c > 0) ? s : -1, (c > 0) ? e - 1 : -1);
    endfunction

    task automatic run_test(input test_t t);
        int     cyc = 0;
        int     idx = 0;
        logic   kept;
        obeat_t e;
        out_cnt = 0; tlast_cnt = 0; first_u = -1; last_u = -1;
        while ((idx < t.nb || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge aclk);
            if (acc_prev) s_axis_tvalid = 1'b0;
            acc_prev = 1'b0;
            m_axis_tready = (t.rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_start = CW'(t.start);
            cfg_len   = (t.chg >= 0 && idx >= t.chg) ? (CW+1)'(t.nlen) : (CW+1)'(t.len);
            cfg_lane  = LW'(t.lane);
            if (!s_axis_tvalid && idx < t.nb && (t.vgap == 0 || $urandom_range(0, 3) != 0)) begin
                for (int w = 0; w < NL * DW / 32; w++) s_axis_tdata[w*32 +: 32] = $urandom();
                s_axis_tlast  = (idx == t.tl);
                s_axis_tvalid = 1'b1;
            end
            #1;
`ifdef FFT_BIN_WINDOW_ERR_EN
            check("err_early_last", err_early_last, exp_early_now);
            check("err_missing_last", err_missing_last, exp_miss_now);
            exp_early_now = 1'b0;
            exp_miss_now  = 1'b0;
`endif
            if (prev_stall)
                check("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                      {1'b1, prev_out});
            kept = model_keep(m_bin);
            if (s_axis_tvalid)
                check("s_ready", s_axis_tready, !(kept && occ == 2));
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", m_axis_tuser, '1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_tuser", m_axis_tuser, e.u);
                    check("out_tdata", m_axis_tdata, e.d);
                    check("out_tlast", m_axis_tlast, e.l);
                end
                if (out_cnt == 0) first_u = int'(m_axis_tuser);
                last_u = int'(m_axis_tuser);
                if (m_axis_tlast) tlast_cnt++;
                out_cnt++;
                occ--;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (m_bin == 0) begin
                    m_start = int'(cfg_start);
                    m_end   = win_end(int'(cfg_start), int'(cfg_len));
                    m_lane  = int'(cfg_lane);
                end
                if (kept) begin
                    e.d = s_axis_tdata[m_lane*DW +: DW];
                    e.l = s_axis_tlast || (m_bin == m_end - 1);
                    e.u = CW'(m_bin);
                    exp_q.push_back(e);
                    occ++;
                end
`ifdef FFT_BIN_WINDOW_ERR_EN
                exp_early_now = s_axis_tlast && (m_bin != N - 1);
                exp_miss_now  = !s_axis_tlast && (m_bin == N - 1);
`endif
                m_bin = (s_axis_tlast || m_bin == N - 1) ? 0 : m_bin + 1;
                acc_prev = 1'b1;
                idx++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            cyc++;
        end
        check("frame_timeout", (cyc >= 4000), 1'b0);
        check("out_count", out_cnt, t.cnt);
        check("first_tuser", first_u, t.fu);
        check("last_tuser", last_u, t.lu);
        check("tlast_count", tlast_cnt, (t.cnt > 0) ? 1 : 0);
    endtask

    initial begin
        test_t tests[$];
        tests.push_back(mk(0,   256, 0, N,   N-1, 0, 0, -1, 0, 256, 0,   255));
        tests.push_back(mk(100, 8,   3, N,   N-1, 0, 0, -1, 0, 8,   100, 107));
        tests.push_back(mk(508, 10,  5, N,   N-1, 0, 0, -1, 0, 4,   508, 511));
        tests.push_back(mk(0,   256, 2, N,   N-1, 1, 1, -1, 0, 256, 0,   255));
        tests.push_back(mk(10,  20,  7, 16,  15,  1, 0, -1, 0, 6,   10,  15));
        tests.push_back(mk(30,  0,   1, 64,  63,  0, 1, -1, 0, 0,   -1,  -1));
        tests.push_back(mk(40,  4,   0, N,   N-1, 1, 0, 50, 2, 4,   40,  43));
        tests.push_back(mk(40,  2,   0, N,   N-1, 0, 0, -1, 0, 2,   40,  41));
        tests.push_back(mk(505, 7,   6, N,   -1,  1, 1, -1, 0, 7,   505, 511));
        tests.push_back(mk(200, 50,  4, 301, 300, 1, 0, -1, 0, 50,  200, 249));
        tests.push_back(mk(0,   1,   1, 4,   3,   0, 0, -1, 0, 1,   0,   0));
        for (int i = 0; i < 3; i++) tests.push_back(mk_rand());

        repeat (3) @(negedge aclk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tuser", m_axis_tuser, '0);
        check("rst_s_ready", s_axis_tready, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("s_ready_before_edge", s_axis_tready, 1'b0);
        @(negedge aclk);
        #1;
        check("s_ready_after_edge", s_axis_tready, 1'b1);

        foreach (tests[i]) run_test(tests[i]);

        // Fill the buffer in KEEP with the sink stalled, then reset mid-frame.
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        acc_prev = 1'b0;
        cfg_start = '0; cfg_len = (CW+1)'(256); cfg_lane = '0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            for (int w = 0; w < NL * DW / 32; w++) s_axis_tdata[w*32 +: 32] = $urandom();
            s_axis_tlast  = 1'b0;
            s_axis_tvalid = 1'b1;
        end
        #1;
        check("full_s_ready", s_axis_tready, 1'b0);
        check("full_tvalid", m_axis_tvalid, 1'b1);
        check("full_head_tuser", m_axis_tuser, '0);
        @(negedge aclk);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 1'b0);
        check("midrst_s_ready", s_axis_tready, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_bin = 0; occ = 0; exp_q.delete(); prev_stall = 1'b0; acc_prev = 1'b0;
`ifdef FFT_BIN_WINDOW_ERR_EN
        exp_early_now = 1'b0;
        exp_miss_now  = 1'b0;
`endif
        run_test(mk(3, 2, 1, 8, 7, 0, 0, -1, 0, 2, 3, 4));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit, got %0d/%0d", passes, checks);
        $fatal(1);
    end
endmodule
